// File: rtl/wall_pkg.sv
// Shared types and constants for the wall scanner.
//   wall_entry_t  : one programmable rectangular region (inclusive bounds, side mask, enable)
//   M_*           : bit positions inside the side mask
//   scan_state_t  : scanner FSM states
//   LEVEL1_WALLS  : table contents loaded on reset (screen edges of a 640x480 playfield)
package wall_pkg;

  localparam int unsigned WALL_COORD_W = 10;

  localparam int unsigned M_LEFT  = 0;
  localparam int unsigned M_RIGHT = 1;
  localparam int unsigned M_ABOVE = 2;
  localparam int unsigned M_BELOW = 3;

  typedef struct packed {
    logic [WALL_COORD_W-1:0] x_min;
    logic [WALL_COORD_W-1:0] x_max;
    logic [WALL_COORD_W-1:0] y_min;
    logic [WALL_COORD_W-1:0] y_max;
    logic [3:0]              mask;
    logic                    enable;
  } wall_entry_t;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_t;

  function automatic wall_entry_t mk_wall(input logic [WALL_COORD_W-1:0] x_min,
                                          input logic [WALL_COORD_W-1:0] x_max,
                                          input logic [WALL_COORD_W-1:0] y_min,
                                          input logic [WALL_COORD_W-1:0] y_max,
                                          input logic [3:0]              mask);
    wall_entry_t w;
    w.x_min  = x_min;
    w.x_max  = x_max;
    w.y_min  = y_min;
    w.y_max  = y_max;
    w.mask   = mask;
    w.enable = 1'b1;
    return w;
  endfunction

  localparam int unsigned LEVEL1_COUNT = 4;

  // Index 0 is the rightmost element of the concatenation.
  localparam wall_entry_t [LEVEL1_COUNT-1:0] LEVEL1_WALLS = {
    mk_wall(10'd0,   10'd639, 10'd479, 10'd479, 4'b1000),  // 3: bottom edge
    mk_wall(10'd0,   10'd639, 10'd0,   10'd0,   4'b0100),  // 2: top edge
    mk_wall(10'd639, 10'd639, 10'd0,   10'd479, 4'b0010),  // 1: right edge
    mk_wall(10'd0,   10'd0,   10'd0,   10'd479, 4'b0001)   // 0: left edge
  };

endpackage

// File: rtl/wall_scanner_if.sv
// Table write port of the wall scanner (valid/ready).
//   master : level/map control, drives the write request and entry fields
//   slave  : wall_scanner, returns wr_ready
interface wall_scanner_if #(
  parameter int unsigned COORD_W = 10,
  parameter int unsigned IDX_W   = 4
);
  logic               wr_valid;
  logic               wr_ready;
  logic [IDX_W-1:0]   wr_idx;
  logic [COORD_W-1:0] wr_x_min;
  logic [COORD_W-1:0] wr_x_max;
  logic [COORD_W-1:0] wr_y_min;
  logic [COORD_W-1:0] wr_y_max;
  logic [3:0]         wr_mask;
  logic               wr_enable;

  modport master (
    output wr_valid, wr_idx, wr_x_min, wr_x_max, wr_y_min, wr_y_max, wr_mask, wr_enable,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_idx, wr_x_min, wr_x_max, wr_y_min, wr_y_max, wr_mask, wr_enable,
    output wr_ready
  );
endinterface

// File: rtl/wall_rect_match.sv
// Combinational point-in-rectangle test.
//   entry : table entry under test
//   px/py : sampled player position
//   match : entry enabled and point inside the inclusive bounds (inverted bounds never match)
module wall_rect_match
  import wall_pkg::*;
#(
  parameter int unsigned COORD_W = WALL_COORD_W
) (
  input  wall_entry_t        entry,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  output logic               match
);

  // The side mask is applied by the scanner, not here.
  logic unused_mask;
  assign unused_mask = ^entry.mask;

  assign match = entry.enable &&
                 (entry.x_min <= px) && (px <= entry.x_max) &&
                 (entry.y_min <= py) && (py <= entry.y_max);

endmodule

// File: rtl/wall_scanner.sv
// Table-driven wall checker. On start, samples ManX/ManY and walks the region table one
// entry per cycle, OR-ing side masks of matching entries; results publish with a done pulse.
//   Clk/Reset      : clock, synchronous active-high reset (reloads the level-1 table)
//   start,ManX/Y   : scan request and player position
//   wr             : table write port (accepted only while idle)
//   busy/done      : scan in progress / one-cycle result strobe
//   wall_*,hit_any,first_hit : registered scan results
module wall_scanner
  import wall_pkg::*;
#(
  parameter int unsigned  COORD_W   = WALL_COORD_W,
  parameter int unsigned  NUM_WALLS = 16,
  localparam int unsigned IDX_W     = $clog2(NUM_WALLS)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start,
  input  logic [COORD_W-1:0] ManX,
  input  logic [COORD_W-1:0] ManY,
  wall_scanner_if.slave      wr,
  output logic               busy,
  output logic               done,
  output logic               wall_left,
  output logic               wall_right,
  output logic               wall_above,
  output logic               wall_below,
  output logic               hit_any,
  output logic [IDX_W-1:0]   first_hit
);

  scan_state_t        state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [COORD_W-1:0] sx_q, sx_d, sy_q, sy_d;
  logic [3:0]         acc_mask_q, acc_mask_d;
  logic               acc_hit_q, acc_hit_d;
  logic [IDX_W-1:0]   acc_first_q, acc_first_d;
  logic [3:0]         res_mask_q;
  logic               res_hit_q;
  logic [IDX_W-1:0]   res_first_q;
  logic               publish;

  wall_entry_t table_q [NUM_WALLS];
  wall_entry_t cur_entry, wr_entry;
  logic        cur_match, wr_fire;

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign wr.wr_ready = !busy;
  assign wr_fire     = wr.wr_valid && wr.wr_ready;

  always_comb begin
    wr_entry.x_min  = wr.wr_x_min;
    wr_entry.x_max  = wr.wr_x_max;
    wr_entry.y_min  = wr.wr_y_min;
    wr_entry.y_max  = wr.wr_y_max;
    wr_entry.mask   = wr.wr_mask;
    wr_entry.enable = wr.wr_enable;
  end

  // Per-entry registers so each entry can carry its own reset value.
  for (genvar g = 0; g < NUM_WALLS; g++) begin : g_entry
    wall_entry_t init_val;
    if (g < LEVEL1_COUNT) begin : g_level1
      assign init_val = LEVEL1_WALLS[g];
    end else begin : g_empty
      assign init_val = '0;
    end

    always_ff @(posedge Clk) begin
      if (Reset) begin
        table_q[g] <= init_val;
      end else if (wr_fire && (wr.wr_idx == IDX_W'(g))) begin
        table_q[g] <= wr_entry;
      end
    end
  end

  assign cur_entry = table_q[idx_q];

  wall_rect_match #(
    .COORD_W (COORD_W)
  ) u_match (
    .entry (cur_entry),
    .px    (sx_q),
    .py    (sy_q),
    .match (cur_match)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    acc_mask_d  = acc_mask_q;
    acc_hit_d   = acc_hit_q;
    acc_first_d = acc_first_q;
    publish     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sx_d        = ManX;
          sy_d        = ManY;
          acc_mask_d  = '0;
          acc_hit_d   = 1'b0;
          acc_first_d = '0;
          idx_d       = '0;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        if (cur_match) begin
          acc_mask_d = acc_mask_q | cur_entry.mask;
          if (!acc_hit_q) acc_first_d = idx_q;
          acc_hit_d  = 1'b1;
        end
        if (idx_q == IDX_W'(NUM_WALLS - 1)) begin
          // Load results on the last scan edge so they are visible alongside done.
          publish = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      sx_q        <= '0;
      sy_q        <= '0;
      acc_mask_q  <= '0;
      acc_hit_q   <= 1'b0;
      acc_first_q <= '0;
      res_mask_q  <= '0;
      res_hit_q   <= 1'b0;
      res_first_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      acc_mask_q  <= acc_mask_d;
      acc_hit_q   <= acc_hit_d;
      acc_first_q <= acc_first_d;
      if (publish) begin
        res_mask_q  <= acc_mask_d;
        res_hit_q   <= acc_hit_d;
        res_first_q <= acc_first_d;
      end
    end
  end

  assign wall_left  = res_mask_q[M_LEFT];
  assign wall_right = res_mask_q[M_RIGHT];
  assign wall_above = res_mask_q[M_ABOVE];
  assign wall_below = res_mask_q[M_BELOW];
  assign hit_any    = res_hit_q;
  assign first_hit  = res_first_q;

endmodule

// File: tb/tb_wall_scanner.sv
module tb_wall_scanner;

  localparam int NW  = 16;
  localparam int LAT = NW + 1;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       start;
  logic [9:0] ManX, ManY;
  logic       busy, done;
  logic       wall_left, wall_right, wall_above, wall_below, hit_any;
  logic [3:0] first_hit;

  int n_tests = 0;
  int n_fail  = 0;

  wall_scanner_if #(.COORD_W(10), .IDX_W(4)) wr_if ();

  wall_scanner #(
    .COORD_W   (10),
    .NUM_WALLS (NW)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .start      (start),
    .ManX       (ManX),
    .ManY       (ManY),
    .wr         (wr_if),
    .busy       (busy),
    .done       (done),
    .wall_left  (wall_left),
    .wall_right (wall_right),
    .wall_above (wall_above),
    .wall_below (wall_below),
    .hit_any    (hit_any),
    .first_hit  (first_hit)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int do_wr;
    int idx, xmin, xmax, ymin, ymax, mask, en;
    int x, y;
    int emask, ehit, efirst;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_result(input string p, input int emask, input int ehit, input int efirst);
    check({p, " mask"}, int'({wall_below, wall_above, wall_right, wall_left}), emask);
    check({p, " hit_any"}, int'(hit_any), ehit);
    check({p, " first_hit"}, int'(first_hit), efirst);
  endtask

  task automatic drive_wr(input int idx, input int xmin, input int xmax, input int ymin,
                          input int ymax, input int mask, input int en);
    wr_if.wr_idx    = 4'(idx);
    wr_if.wr_x_min  = 10'(xmin);
    wr_if.wr_x_max  = 10'(xmax);
    wr_if.wr_y_min  = 10'(ymin);
    wr_if.wr_y_max  = 10'(ymax);
    wr_if.wr_mask   = 4'(mask);
    wr_if.wr_enable = 1'(en);
    wr_if.wr_valid  = 1'b1;
  endtask

  task automatic write_entry(input int idx, input int xmin, input int xmax, input int ymin,
                             input int ymax, input int mask, input int en);
    int n;
    n = 0;
    @(posedge Clk); #1;
    drive_wr(idx, xmin, xmax, ymin, ymax, mask, en);
    while (!wr_if.wr_ready && n < 40) begin
      @(posedge Clk); #1;
      n++;
    end
    if (n >= 40) check("write ready timeout", int'(wr_if.wr_ready), 1);
    @(posedge Clk); #1;
    wr_if.wr_valid = 1'b0;
  endtask

  // Returns the cycle (start cycle = 0) in which done was seen, or 40 on timeout.
  task automatic run_scan(input int x, input int y, output int lat);
    @(posedge Clk); #1;
    ManX  = 10'(x);
    ManY  = 10'(y);
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 40) begin
      @(posedge Clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, done_cnt, done_cyc, acc_cyc, sa_hit;

    //          wr idx xmin xmax ymin ymax mask en   x    y   emask hit first
    vecs[0]  = '{1, 3,  80, 388, 294, 294, 4, 1,   80, 294, 4, 1, 3};
    vecs[1]  = '{0, 0,   0,   0,   0,   0, 0, 0,  389, 294, 0, 0, 0};
    vecs[2]  = '{0, 0,   0,   0,   0,   0, 0, 0,  388, 294, 4, 1, 3};
    vecs[3]  = '{1, 1,  76,  90, 216, 293, 2, 1,   80, 250, 2, 1, 1};
    vecs[4]  = '{1, 5,   0,  37, 216, 479, 1, 1,   30, 250, 1, 1, 5};
    vecs[5]  = '{1, 1,   0,  90, 216, 293, 2, 1,   30, 250, 3, 1, 1};
    vecs[6]  = '{0, 0,   0,   0,   0,   0, 0, 0,   80, 293, 2, 1, 1};
    vecs[7]  = '{0, 0,   0,   0,   0,   0, 0, 0,   37, 479, 1, 1, 5};
    vecs[8]  = '{1, 7, 100,  50,   0, 479, 8, 1,   75, 300, 0, 0, 0};
    vecs[9]  = '{1, 9,   0,1023,   0,1023, 0, 1,  500, 500, 0, 1, 9};
    vecs[10] = '{1, 9,   0,1023,   0,1023, 0, 0,  500, 500, 0, 0, 0};

    Reset = 1'b1;
    start = 1'b0;
    ManX  = '0;
    ManY  = '0;
    wr_if.wr_valid = 1'b0;
    drive_wr(0, 0, 0, 0, 0, 0, 0);
    wr_if.wr_valid = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;

    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset wr_ready", int'(wr_if.wr_ready), 1);
    check_result("reset", 0, 0, 0);

    // Level-1 left edge entry.
    run_scan(0, 100, lat);
    check("level1 latency", lat, LAT);
    check_result("level1", 1, 1, 0);

    for (int i = 0; i < NW; i++) write_entry(i, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].do_wr != 0)
        write_entry(vecs[i].idx, vecs[i].xmin, vecs[i].xmax, vecs[i].ymin, vecs[i].ymax,
                    vecs[i].mask, vecs[i].en);
      run_scan(vecs[i].x, vecs[i].y, lat);
      check($sformatf("v%0d latency", i), lat, LAT);
      check_result($sformatf("v%0d", i), vecs[i].emask, vecs[i].ehit, vecs[i].efirst);
    end

    // Second start mid-scan is dropped; write during scan stalls until idle.
    @(posedge Clk); #1;
    ManX = 10'd205;
    ManY = 10'd205;
    done_cnt = 0;
    done_cyc = -1;
    acc_cyc  = -1;
    sa_hit   = -1;
    for (int c = 0; c < 24; c++) begin
      start = (c == 0 || c == 3);
      if (c == 2) begin
        drive_wr(11, 200, 210, 200, 210, 8, 1);
        check("busy write ready", int'(wr_if.wr_ready), 0);
        check("busy flag", int'(busy), 1);
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
        sa_hit   = int'(hit_any);
      end
      if (wr_if.wr_valid && wr_if.wr_ready && acc_cyc < 0) acc_cyc = c;
      @(posedge Clk); #1;
      if (acc_cyc >= 0) wr_if.wr_valid = 1'b0;
    end
    start = 1'b0;
    check("double start done count", done_cnt, 1);
    check("double start done cycle", done_cyc, LAT);
    check("stalled write accept cycle", acc_cyc, LAT + 1);
    check("stalled write not seen", sa_hit, 0);
    run_scan(205, 205, lat);
    check("post-stall latency", lat, LAT);
    check_result("post-stall", 8, 1, 11);

    // Reset in the middle of a scan.
    @(posedge Clk); #1;
    ManX = 10'd0;
    ManY = 10'd100;
    done_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      start = (c == 0);
      Reset = (c == 5);
      if (done) done_cnt++;
      if (c == 6) begin
        check("abort busy", int'(busy), 0);
        check_result("abort", 0, 0, 0);
      end
      @(posedge Clk); #1;
    end
    start = 1'b0;
    Reset = 1'b0;
    check("abort done count", done_cnt, 0);
    run_scan(0, 100, lat);
    check("after abort latency", lat, LAT);
    check_result("after abort", 1, 1, 0);

    // Write and start in the same idle cycle: scan uses the new entry 0.
    @(posedge Clk); #1;
    drive_wr(0, 60, 90, 90, 110, 2, 1);
    ManX  = 10'd75;
    ManY  = 10'd100;
    start = 1'b1;
    @(posedge Clk); #1;
    wr_if.wr_valid = 1'b0;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge Clk); #1;
      lat++;
    end
    check("same-cycle latency", lat, LAT);
    check_result("same-cycle", 2, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
